uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one uart_full transmitter between NREQ requesters using round-robin arbitration. Each requester presents a byte plus its own parity/stop selection over a valid/ready handshake. The block drives the UART's tx_valid_in, data_in, parity_sel, stop_sel and baud_divisor. It times each frame internally from the divisor and the frame length, then frees the transmitter for the next grant.

Parameters:
NREQ, 4, number of requesters (2..8)
GAP_CYCLES, 2, idle clocks inserted after each frame before the next grant (0 allowed)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  arbitration enable
baud_divisor_cfg  in  12  clocks per UART bit; 0 treated as 1
req_valid  in  NREQ  per-requester request
req_data  in  8*NREQ  byte for requester i in bits [8i+7:8i]
req_parity_sel  in  NREQ  per-requester parity select (0 even, 1 odd)
req_stop_sel  in  NREQ  per-requester stop select (0 one stop bit, 1 two)
req_ready  out  NREQ  one-hot acceptance pulse
tx_valid_in  out  1  to UART: one-cycle frame start
data_in  out  8  to UART: latched byte
parity_sel  out  1  to UART: latched parity select
stop_sel  out  1  to UART: latched stop select
baud_divisor  out  12  to UART: latched divisor
busy  out  1  high from the accept cycle through the end of the gap
grant_id  out  $clog2(NREQ)  index of the current or last granted requester
frame_done  out  1  one-cycle pulse at the end of each frame

Behaviour:
- Reset values: state IDLE, all outputs 0, round-robin pointer 0, counters 0. baud_divisor resets to 0.
- FSM states: IDLE, LOAD, SEND, GAP.
- IDLE:
  - A grant occurs when enable=1 and any req_valid bit is set.
  - The winner is the first set bit searching upward from the pointer, wrapping modulo NREQ.
  - req_ready[winner] is asserted combinationally in this cycle; the handshake completes on that edge.
  - On the same edge: latch data, parity, stop and baud_divisor_cfg (0 becomes 1); update grant_id; set pointer = (winner+1) mod NREQ; set busy=1; go to LOAD.
  - req_ready is 0 in every state other than IDLE.
- LOAD:
  - tx_valid_in=1 for exactly this one cycle.
  - Load the frame counter with div*bits, where bits = 11 (stop_sel=0) or 12 (stop_sel=1).
  - Counter width is 16 bits; the maximum is 4095*12.
  - Go to SEND.
- SEND:
  - Decrement the counter each cycle; lasts exactly div*bits cycles.
  - On the last cycle: go to GAP if GAP_CYCLES>0, otherwise assert frame_done and go to IDLE.
- GAP:
  - Lasts GAP_CYCLES cycles; frame_done is asserted on the final GAP cycle.
  - Next state IDLE with busy=0.
- Output stability: data_in, parity_sel, stop_sel and baud_divisor are held stable from LOAD until the next accept. Changes on the cfg or req inputs mid-frame have no effect until the next grant.
- Earliest next accept: the cycle after frame_done.
- Timing from accept at cycle T:
  - tx_valid_in at T+1.
  - SEND occupies T+2 .. T+1+div*bits.
  - frame_done at T+1+div*bits+GAP_CYCLES.
- enable deasserted mid-frame: the current frame completes normally, including frame_done; no new grant is issued while enable=0.
- A requester dropping req_valid before its grant simply loses eligibility; there is no penalty and the pointer is unchanged.
- Reset asserted in any state: immediate return to reset values. tx_valid_in drops asynchronously. A partially transmitted UART frame is the UART's own reset responsibility.

Test Plan:
1. Single requester 0, data 8'hA5, even parity, 1 stop bit, divisor 10, GAP 2 -> req_ready[0] for 1 cycle. tx_valid_in pulse next cycle with data_in=A5, parity_sel=0. busy for 1+1+110+2 cycles. frame_done 112 cycles after tx_valid_in.
2. Requester 2, data 8'hFF, odd parity, 2 stop bits, divisor 10 -> SEND lasts 120 cycles. stop_sel=1 and parity_sel=1 held throughout. grant_id=2.
3. All four req_valid held high continuously -> grant order 0,1,2,3,0,1. Each grant is separated by a full frame plus gap. Exactly one req_ready bit per grant.
4. Requester 1 granted while baud_divisor_cfg is changed from 10 to 4 mid-SEND -> the current frame still lasts 110 cycles. The next frame uses divisor 4, giving 44 cycles.
5. enable driven low during SEND with requester 3 pending -> the current frame completes and frame_done pulses. No req_ready while enable=0. Requester 3 is granted the first IDLE cycle after enable returns high.
6. reset pulsed mid-SEND, then requesters 2 and 0 both valid with divisor_cfg=0 -> all outputs 0 during reset. After release, requester 0 is granted first (pointer reset). SEND lasts 11 cycles (divisor treated as 1).

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requesters, the arbiter and the shared UART transmitter.
// The arbiter takes the slave modport; the requester/UART side takes the master.
interface uart_tx_arbiter_if #(
  parameter int unsigned NREQ = 4
) ();
  localparam int unsigned IdW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic                  enable;
  logic [11:0]           baud_divisor_cfg;
  logic [NREQ-1:0]       req_valid;
  logic [8*NREQ-1:0]     req_data;
  logic [NREQ-1:0]       req_parity_sel;
  logic [NREQ-1:0]       req_stop_sel;
  logic [NREQ-1:0]       req_ready;
  logic                  tx_valid_in;
  logic [7:0]            data_in;
  logic                  parity_sel;
  logic                  stop_sel;
  logic [11:0]           baud_divisor;
  logic                  busy;
  logic [IdW-1:0]        grant_id;
  logic                  frame_done;

  modport slave (
    input  enable, baud_divisor_cfg, req_valid, req_data, req_parity_sel, req_stop_sel,
    output req_ready, tx_valid_in, data_in, parity_sel, stop_sel, baud_divisor, busy,
           grant_id, frame_done
  );

  modport master (
    output enable, baud_divisor_cfg, req_valid, req_data, req_parity_sel, req_stop_sel,
    input  req_ready, tx_valid_in, data_in, parity_sel, stop_sel, baud_divisor, busy,
           grant_id, frame_done
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ requesters.
// Frame length is timed locally from the latched divisor and stop-bit count.
module uart_tx_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave arb_io
);
  localparam int unsigned    IdW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0]    GapCnt = 16'(GAP_CYCLES);
  localparam logic [IdW-1:0] LastId = IdW'(NREQ - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StGap} state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [IdW-1:0]  gid_q, gid_d;
  logic [7:0]      data_q, data_d;
  logic            par_q, par_d;
  logic            stop_q, stop_d;
  logic [11:0]     div_q, div_d;
  logic [15:0]     cnt_q, cnt_d;

  logic            found;
  logic [IdW-1:0]  win;
  logic [IdW-1:0]  idx;
  logic            grant;
  logic            frame_done;
  logic [NREQ-1:0] ready;

  // First valid requester searching upward from the pointer, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = ptr_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && arb_io.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = (idx == LastId) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gid_d      = gid_q;
    data_d     = data_q;
    par_d      = par_q;
    stop_d     = stop_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    grant      = 1'b0;
    frame_done = 1'b0;
    ready      = '0;
    unique case (state_q)
      StIdle: begin
        // Gated by reset so every output reads 0 while reset is held.
        if (arb_io.enable && found && !reset) begin
          grant      = 1'b1;
          ready[win] = 1'b1;
          gid_d      = win;
          ptr_d      = (win == LastId) ? '0 : win + 1'b1;
          data_d     = arb_io.req_data[{win, 3'b000} +: 8];
          par_d      = arb_io.req_parity_sel[win];
          stop_d     = arb_io.req_stop_sel[win];
          div_d      = (arb_io.baud_divisor_cfg == 12'd0) ? 12'd1 : arb_io.baud_divisor_cfg;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = 16'(div_q) * (stop_q ? 16'd12 : 16'd11);
        state_d = StSend;
      end
      StSend: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          if (GAP_CYCLES > 0) begin
            cnt_d   = GapCnt;
            state_d = StGap;
          end else begin
            frame_done = 1'b1;
            state_d    = StIdle;
          end
        end
      end
      StGap: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          frame_done = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gid_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      div_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
    end
  end

  assign arb_io.req_ready    = ready;
  assign arb_io.tx_valid_in  = (state_q == StLoad);
  assign arb_io.data_in      = data_q;
  assign arb_io.parity_sel   = par_q;
  assign arb_io.stop_sel     = stop_q;
  assign arb_io.baud_divisor = div_q;
  assign arb_io.busy         = (state_q != StIdle) || grant;
  assign arb_io.grant_id     = gid_q;
  assign arb_io.frame_done   = frame_done;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant order, frame timing, latching, enable and reset.
module tb_uart_tx_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned GAP  = 2;

  logic clk;
  logic reset;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(
    .NREQ      (NREQ),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .arb_io(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Event log filled on the falling edge, well away from the active edge.
  int          cyc = 0;
  int          acc_cnt = 0, tx_cnt = 0, done_cnt = 0;
  int          acc_cyc = 0, tx_cyc = 0, done_cyc = 0;
  logic [7:0]  tx_data = '0;
  logic        tx_par = 1'b0, tx_stop = 1'b0;
  logic [11:0] tx_div = '0;
  logic        in_frame = 1'b0;
  logic        hold_err = 1'b0, onehot_err = 1'b0, dis_err = 1'b0;
  int          busy_run = 0, busy_len = 0;
  int          grants[$];
  int          acc_cycs[$];

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      in_frame <= 1'b0;
      busy_run <= 0;
    end else begin
      if (|bus.req_ready) begin
        acc_cnt <= acc_cnt + 1;
        acc_cyc <= cyc + 1;
        grants.push_back(oh2idx(bus.req_ready));
        acc_cycs.push_back(cyc + 1);
        if ($countones(bus.req_ready) != 1) onehot_err <= 1'b1;
        if (!bus.enable) dis_err <= 1'b1;
      end
      if (bus.tx_valid_in) begin
        tx_cnt   <= tx_cnt + 1;
        tx_cyc   <= cyc + 1;
        tx_data  <= bus.data_in;
        tx_par   <= bus.parity_sel;
        tx_stop  <= bus.stop_sel;
        tx_div   <= bus.baud_divisor;
        in_frame <= 1'b1;
      end else if (in_frame && (bus.data_in != tx_data || bus.parity_sel != tx_par ||
                                bus.stop_sel != tx_stop || bus.baud_divisor != tx_div)) begin
        hold_err <= 1'b1;
      end
      if (bus.frame_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc + 1;
        in_frame <= 1'b0;
      end
      if (bus.busy) busy_run <= busy_run + 1;
      else if (busy_run != 0) begin
        busy_len <= busy_run;
        busy_run <= 0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns one tick after the accepting edge.
  task automatic wait_acc(input int budget);
    int s = acc_cnt;
    int n = 0;
    while (acc_cnt == s && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("acc_wait", 32'(acc_cnt != s), 32'd1);
    tick(1);
  endtask

  // Returns just after the falling edge of the frame_done cycle.
  task automatic wait_done(input int budget);
    int s = done_cnt;
    int n = 0;
    while (done_cnt == s && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("done_wait", 32'(done_cnt != s), 32'd1);
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic p, input logic s);
    bus.req_data[8*i +: 8] = d;
    bus.req_parity_sel[i]  = p;
    bus.req_stop_sel[i]    = s;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_out"}, {bus.busy, bus.tx_valid_in, bus.frame_done, bus.parity_sel,
                             bus.stop_sel, 27'(bus.req_ready)}, 32'd0);
    check_eq({tag, "_bus"}, {bus.data_in, bus.baud_divisor, 10'(bus.grant_id)}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    check_outputs_zero("reset");
    reset = 1'b0;
  endtask

  initial begin
    int exp_cyc;
    int s;
    reset                = 1'b1;
    bus.enable           = 1'b0;
    bus.baud_divisor_cfg = '0;
    bus.req_valid        = '0;
    bus.req_data         = '0;
    bus.req_parity_sel   = '0;
    bus.req_stop_sel     = '0;
    do_reset();

    // 1: single requester 0, A5, even, 1 stop, div 10
    bus.enable           = 1'b1;
    bus.baud_divisor_cfg = 12'd10;
    set_req(0, 8'hA5, 1'b0, 1'b0);
    bus.req_valid = 4'b0001;
    wait_acc(20);
    bus.req_valid = '0;
    wait_done(300);
    @(negedge clk);
    #1;
    check_eq("t1_tx_lat", 32'(tx_cyc - acc_cyc), 32'd1);
    check_eq("t1_data", {tx_stop, tx_par, tx_div, 10'd0, tx_data}, {1'b0, 1'b0, 12'd10, 10'd0, 8'hA5});
    check_eq("t1_done_lat", 32'(done_cyc - tx_cyc), 32'd112);
    check_eq("t1_busy_len", 32'(busy_len), 32'd114);
    check_eq("t1_gid", 32'(bus.grant_id), 32'd0);

    // 2: requester 2, FF, odd, 2 stop
    set_req(2, 8'hFF, 1'b1, 1'b1);
    tick(1);
    bus.req_valid = 4'b0100;
    wait_acc(20);
    bus.req_valid = '0;
    wait_done(300);
    @(negedge clk);
    #1;
    check_eq("t2_done_lat", 32'(done_cyc - tx_cyc), 32'd122);
    check_eq("t2_sel", {30'd0, tx_stop, tx_par}, 32'd3);
    check_eq("t2_data", 32'(tx_data), 32'hFF);
    check_eq("t2_gid", 32'(bus.grant_id), 32'd2);
    check_eq("t2_busy_len", 32'(busy_len), 32'd124);
    check_eq("t2_hold", 32'(hold_err), 32'd0);

    // 3: all requesters pending, div 2 -> 26-cycle grant spacing
    tick(1);
    do_reset();
    set_req(1, 8'h11, 1'b0, 1'b0);
    set_req(3, 8'h33, 1'b0, 1'b0);
    set_req(2, 8'h22, 1'b0, 1'b0);
    bus.baud_divisor_cfg = 12'd2;
    grants.delete();
    acc_cycs.delete();
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) wait_done(100);
    tick(1);
    bus.req_valid = '0;
    check_eq("t3_ngrants", 32'(grants.size()), 32'd6);
    if (grants.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        check_eq($sformatf("t3_order%0d", k), 32'(grants[k]), 32'(k % 4));
        if (k > 0) check_eq($sformatf("t3_gap%0d", k), 32'(acc_cycs[k] - acc_cycs[k-1]), 32'd26);
      end
    end
    check_eq("t3_onehot", 32'(onehot_err), 32'd0);

    // 4: divisor changed mid-frame applies only to the next frame
    bus.baud_divisor_cfg = 12'd10;
    bus.req_valid        = 4'b0010;
    wait_acc(20);
    tick(20);
    bus.baud_divisor_cfg = 12'd4;
    wait_done(300);
    check_eq("t4_len1", 32'(done_cyc - tx_cyc), 32'd112);
    check_eq("t4_div1", 32'(tx_div), 32'd10);
    wait_acc(20);
    bus.req_valid = '0;
    wait_done(200);
    check_eq("t4_len2", 32'(done_cyc - tx_cyc), 32'd46);
    check_eq("t4_div2", 32'(tx_div), 32'd4);
    check_eq("t4_hold", 32'(hold_err), 32'd0);

    // 5: enable dropped mid-frame with requester 3 waiting
    tick(1);
    bus.req_valid = 4'b0001;
    wait_acc(20);
    bus.req_valid = 4'b1000;
    tick(10);
    bus.enable = 1'b0;
    wait_done(200);
    check_eq("t5_len", 32'(done_cyc - tx_cyc), 32'd46);
    s = acc_cnt;
    tick(10);
    check_eq("t5_no_grant", 32'(acc_cnt - s), 32'd0);
    check_eq("t5_dis", 32'(dis_err), 32'd0);
    bus.enable = 1'b1;
    exp_cyc    = cyc + 1;
    wait_acc(20);
    check_eq("t5_acc_cyc", 32'(acc_cyc), 32'(exp_cyc));
    check_eq("t5_gid", 32'(grants[$]), 32'd3);
    bus.req_valid = '0;
    wait_done(200);

    // 6: reset mid-frame, then divisor 0 with requesters 2 and 0 pending
    tick(1);
    bus.baud_divisor_cfg = 12'd10;
    bus.req_valid        = 4'b0010;
    wait_acc(20);
    bus.req_valid = '0;
    tick(8);
    reset = 1'b1;
    #1;
    check_outputs_zero("t6_async");
    bus.req_valid        = 4'b0101;
    bus.baud_divisor_cfg = 12'd0;
    tick(2);
    check_outputs_zero("t6_held");
    reset = 1'b0;
    wait_acc(20);
    check_eq("t6_first", 32'(grants[$]), 32'd0);
    bus.req_valid = 4'b0100;
    wait_done(100);
    check_eq("t6_len", 32'(done_cyc - tx_cyc), 32'd13);
    check_eq("t6_div", 32'(tx_div), 32'd1);
    wait_acc(20);
    check_eq("t6_second", 32'(grants[$]), 32'd2);
    bus.req_valid = '0;
    wait_done(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
